// File: rtl/edge_pkg.sv
// Shared types and constants for the edge-detection pipeline.
// Window tap layout: tap k = 3*row + col, row 0 on top, col 0 on the left.
package edge_pkg;

    localparam int DEFAULT_SUBPIXEL_DEPTH = 8;

    localparam int WINDOW_ROWS   = 3;
    localparam int WINDOW_TAPS   = 9;
    localparam int TAP_TOP_RIGHT = 2;
    localparam int TAP_CENTER    = 4;
    localparam int TAP_MID_RIGHT = 5;
    localparam int TAP_BOT_RIGHT = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_DONE
    } window_state_t;

endpackage

// File: rtl/line_buffer.sv
// One-row delay line addressed by column.
// Combinational read returns the old word while the same address is written.
module line_buffer #(
    parameter int P_DEPTH = 64,
    parameter int P_WIDTH = 8
) (
    input  logic                       I_CLK,
    input  logic                       I_EN,
    input  logic [$clog2(P_DEPTH)-1:0] I_ADDR,
    input  logic [P_WIDTH-1:0]         I_DATA,
    output logic [P_WIDTH-1:0]         O_DATA
);

    logic [P_WIDTH-1:0] mem [P_DEPTH];

    assign O_DATA = mem[I_ADDR];

    // Storage is never reset; stale rows are overwritten before use.
    always_ff @(posedge I_CLK) begin
        if (I_EN) begin
            mem[I_ADDR] <= I_DATA;
        end
    end

endmodule

// File: rtl/window_3x3.sv
// Streaming 3x3 neighbourhood generator for interior pixels.
// Two row buffers plus a shifting register window; outputs are registered.
module window_3x3
    import edge_pkg::*;
#(
    parameter int P_SUBPIXEL_DEPTH = DEFAULT_SUBPIXEL_DEPTH,
    parameter int P_IMAGE_WIDTH    = 64,
    parameter int P_IMAGE_HEIGHT   = 64
) (
    input  logic                                I_CLK,
    input  logic                                I_RESET,
    input  logic                                I_VALID,
    input  logic                                I_SOF,
    input  logic [P_SUBPIXEL_DEPTH-1:0]         I_PIXEL,
    output logic                                O_VALID,
    output logic [9*P_SUBPIXEL_DEPTH-1:0]       O_WINDOW,
    output logic [$clog2(P_IMAGE_WIDTH)-1:0]    O_X,
    output logic [$clog2(P_IMAGE_HEIGHT)-1:0]   O_Y,
    output logic                                O_FRAME_DONE
);

    localparam int D  = P_SUBPIXEL_DEPTH;
    localparam int XW = $clog2(P_IMAGE_WIDTH);
    localparam int YW = $clog2(P_IMAGE_HEIGHT);

    typedef logic [WINDOW_TAPS-1:0][D-1:0] window_t;

    window_state_t state;
    window_state_t state_nxt;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;

    logic          sof_hit;
    logic          accept;
    logic          last_col;
    logic          last_row;
    logic          emit;
    logic          frame_end;

    logic [D-1:0]  lb0_q;
    logic [D-1:0]  lb1_q;

    window_t       win;
    window_t       win_nxt;

    assign sof_hit = I_VALID & I_SOF;
    assign accept  = sof_hit
                   | (I_VALID & ((state == S_FILL) | (state == S_STREAM)));

    // A start-of-frame pixel is always (0,0), whatever the counters say.
    assign cur_x = sof_hit ? '0 : x;
    assign cur_y = sof_hit ? '0 : y;

    assign last_col = (cur_x == XW'(P_IMAGE_WIDTH - 1));
    assign last_row = (cur_y == YW'(P_IMAGE_HEIGHT - 1));

    assign emit = accept & ~sof_hit
                & (cur_x >= XW'(2)) & (cur_y >= YW'(2));

    assign frame_end = accept & ~sof_hit & (state == S_STREAM)
                     & last_col & last_row;

    line_buffer #(
        .P_DEPTH (P_IMAGE_WIDTH),
        .P_WIDTH (D)
    ) u_lb0 (
        .I_CLK  (I_CLK),
        .I_EN   (accept),
        .I_ADDR (cur_x),
        .I_DATA (I_PIXEL),
        .O_DATA (lb0_q)
    );

    line_buffer #(
        .P_DEPTH (P_IMAGE_WIDTH),
        .P_WIDTH (D)
    ) u_lb1 (
        .I_CLK  (I_CLK),
        .I_EN   (accept),
        .I_ADDR (cur_x),
        .I_DATA (lb0_q),
        .O_DATA (lb1_q)
    );

    // Frame-phase register.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame-phase transitions; a mid-frame SOF restarts filling.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (sof_hit) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (sof_hit) begin
                    state_nxt = S_FILL;
                end else if (accept && last_col && cur_y == YW'(1)) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (sof_hit) begin
                    state_nxt = S_FILL;
                end else if (frame_end) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = sof_hit ? S_FILL : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Raster position of the next expected pixel.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            x <= '0;
            y <= '0;
        end else if (accept) begin
            if (last_col) begin
                x <= '0;
                y <= last_row ? '0 : cur_y + YW'(1);
            end else begin
                x <= cur_x + XW'(1);
                y <= cur_y;
            end
        end
    end

    // Shift window left and append the column ending at the new pixel.
    always_comb begin
        win_nxt = win;
        for (int r = 0; r < WINDOW_ROWS; r++) begin
            win_nxt[3*r]     = win[3*r + 1];
            win_nxt[3*r + 1] = win[3*r + 2];
        end
        win_nxt[TAP_TOP_RIGHT] = lb1_q;
        win_nxt[TAP_MID_RIGHT] = lb0_q;
        win_nxt[TAP_BOT_RIGHT] = I_PIXEL;
    end

    // Working window advances on every accepted pixel.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            win <= '0;
        end else if (accept) begin
            win <= win_nxt;
        end
    end

    // Output registers update only when a complete neighbourhood exists.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            O_VALID      <= 1'b0;
            O_FRAME_DONE <= 1'b0;
            O_WINDOW     <= '0;
            O_X          <= '0;
            O_Y          <= '0;
        end else begin
            O_VALID      <= emit;
            O_FRAME_DONE <= frame_end;
            if (emit) begin
                O_WINDOW <= win_nxt;
                O_X      <= cur_x - XW'(1);
                O_Y      <= cur_y - YW'(1);
            end
        end
    end

endmodule

// File: tb/tb_window_3x3.sv
// Directed bench for window_3x3 on a 4x4 image, pixel = 16*y + x.
// Every step checks the registered outputs one cycle after the input.
module tb_window_3x3;

    localparam int D = 8;
    localparam int W = 4;
    localparam int H = 4;

    logic           clk;
    logic           rst;
    logic           i_valid;
    logic           i_sof;
    logic [D-1:0]   i_pixel;
    logic           o_valid;
    logic [9*D-1:0] o_window;
    logic [1:0]     o_x;
    logic [1:0]     o_y;
    logic           o_frame_done;

    int n_assert;
    int n_fail;
    int win_cnt;
    int done_cnt;

    window_3x3 #(
        .P_SUBPIXEL_DEPTH (D),
        .P_IMAGE_WIDTH    (W),
        .P_IMAGE_HEIGHT   (H)
    ) dut (
        .I_CLK        (clk),
        .I_RESET      (rst),
        .I_VALID      (i_valid),
        .I_SOF        (i_sof),
        .I_PIXEL      (i_pixel),
        .O_VALID      (o_valid),
        .O_WINDOW     (o_window),
        .O_X          (o_x),
        .O_Y          (o_y),
        .O_FRAME_DONE (o_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [71:0] got,
                         input logic [71:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int cx, input int cy);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w[(3*r + c)*8 +: 8] = 8'(16*(cy - 1 + r) + (cx - 1 + c));
            end
        end
        return w;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [D-1:0] p);
        i_valid = v;
        i_sof   = s;
        i_pixel = p;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input int x, input int y);
        logic e;
        e = (x >= 2) && (y >= 2);
        check("valid", 72'(o_valid), 72'(e));
        check("frame_done", 72'(o_frame_done), 72'((x == W-1) && (y == H-1)));
        if (e) begin
            check("o_x", 72'(o_x), 72'(x - 1));
            check("o_y", 72'(o_y), 72'(y - 1));
            check("window", o_window, exp_win(x - 1, y - 1));
        end
        if (o_valid === 1'b1) win_cnt++;
        if (o_frame_done === 1'b1) done_cnt++;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 8'h55);
        check("bubble_valid", 72'(o_valid), 72'(0));
        check("bubble_done", 72'(o_frame_done), 72'(0));
    endtask

    task automatic frame(input bit gaps, input int npix);
        int x;
        int y;
        for (int i = 0; i < npix; i++) begin
            x = i % W;
            y = i / W;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) bubble();
            end
            drive(1'b1, i == 0, 8'(16*y + x));
            check_out(x, y);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_sof    = 1'b0;
        i_pixel  = '0;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_valid", 72'(o_valid), 72'(0));
        check("rst_done", 72'(o_frame_done), 72'(0));
        check("rst_window", o_window, 72'(0));
        check("rst_x", 72'(o_x), 72'(0));
        check("rst_y", 72'(o_y), 72'(0));
        rst = 1'b0;

        // 1: continuous frame
        win_cnt = 0; done_cnt = 0;
        frame(1'b0, 16);
        bubble();
        check("hold_x", 72'(o_x), 72'(2));
        check("hold_y", 72'(o_y), 72'(2));
        check("hold_window", o_window, exp_win(2, 2));
        check("s1_windows", 72'(win_cnt), 72'(4));
        check("s1_done", 72'(done_cnt), 72'(1));

        // 2: same frame with random bubbles
        win_cnt = 0; done_cnt = 0;
        frame(1'b1, 16);
        bubble();
        check("s2_windows", 72'(win_cnt), 72'(4));
        check("s2_done", 72'(done_cnt), 72'(1));

        // 3: non-SOF pixels while idle are ignored
        win_cnt = 0; done_cnt = 0;
        repeat (5) begin
            drive(1'b1, 1'b0, 8'hAA);
            check("idle_valid", 72'(o_valid), 72'(0));
            check("idle_done", 72'(o_frame_done), 72'(0));
        end
        frame(1'b0, 16);
        bubble();
        check("s3_windows", 72'(win_cnt), 72'(4));
        check("s3_done", 72'(done_cnt), 72'(1));

        // 4: SOF at (1,2) aborts the frame
        win_cnt = 0; done_cnt = 0;
        frame(1'b0, 9);
        frame(1'b0, 16);
        bubble();
        check("s4_windows", 72'(win_cnt), 72'(4));
        check("s4_done", 72'(done_cnt), 72'(1));

        // 5: asynchronous reset mid-stream
        frame(1'b0, 11);
        check("pre_rst_valid", 72'(o_valid), 72'(1));
        i_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 72'(o_valid), 72'(0));
        check("async_done", 72'(o_frame_done), 72'(0));
        check("async_window", o_window, 72'(0));
        check("async_x", 72'(o_x), 72'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            drive(1'b1, 1'b0, 8'hAA);
            check("post_rst_valid", 72'(o_valid), 72'(0));
        end
        win_cnt = 0; done_cnt = 0;
        frame(1'b0, 16);
        bubble();
        check("s5_windows", 72'(win_cnt), 72'(4));
        check("s5_done", 72'(done_cnt), 72'(1));

        // 6: back-to-back frames, SOF in the done cycle
        win_cnt = 0; done_cnt = 0;
        frame(1'b0, 16);
        frame(1'b0, 16);
        bubble();
        check("s6_windows", 72'(win_cnt), 72'(8));
        check("s6_done", 72'(done_cnt), 72'(2));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
